// File: rtl/startup_screen_text_if.sv
// Raster-coordinate, key and overlay-result signals shared by the start screen
// overlay and its driver.
interface startup_screen_text_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       key_pressed;
    logic       restart;
    logic       in_text;
    logic       in_title;
    logic       in_prompt;
    logic       ready;
    logic       start_pulse;

    modport master (
        output pixel_x, pixel_y, key_pressed, restart,
        input  in_text, in_title, in_prompt, ready, start_pulse
    );

    modport slave (
        input  pixel_x, pixel_y, key_pressed, restart,
        output in_text, in_title, in_prompt, ready, start_pulse
    );
endinterface

// File: rtl/startup_screen_text.sv
// Animated start screen overlay: a title that slides down to its rest row, a
// blinking prompt, and a one-cycle start pulse on the first key press.

// Renders a fixed string of 6x8 glyph cells at (x_pos, y_pos); pixel_on is registered.
module string_display #(
    parameter int unsigned          LEN     = 4,
    parameter int unsigned          SCALE   = 8,
    parameter int unsigned          KERNING = 0,
    parameter logic [8*LEN-1:0]     TEXT    = "PONG"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic       pixel_on
);
    localparam int unsigned CELL_W  = 6 * SCALE + KERNING;
    localparam int unsigned SPAN_W  = LEN * CELL_W;
    localparam int unsigned GLYPH_W = 6 * SCALE;
    localparam int unsigned GLYPH_H = 8 * SCALE;

    // Row-major 6x8 bitmap, bit 47 is the top-left pixel; unknown characters are blank.
    function automatic logic [47:0] glyph(input logic [7:0] ch);
        case (ch)
            "P": glyph = {6'b111100, 6'b100010, 6'b100010, 6'b111100, 6'b100000, 6'b100000, 6'b100000, 6'b000000};
            "O": glyph = {6'b011100, 6'b100010, 6'b100010, 6'b100010, 6'b100010, 6'b100010, 6'b011100, 6'b000000};
            "N": glyph = {6'b100010, 6'b110010, 6'b101010, 6'b100110, 6'b100010, 6'b100010, 6'b100010, 6'b000000};
            "G": glyph = {6'b011100, 6'b100010, 6'b100000, 6'b101110, 6'b100010, 6'b100010, 6'b011110, 6'b000000};
            "r": glyph = {6'b000000, 6'b000000, 6'b101100, 6'b110010, 6'b100000, 6'b100000, 6'b100000, 6'b000000};
            "e": glyph = {6'b000000, 6'b000000, 6'b011100, 6'b100010, 6'b111110, 6'b100000, 6'b011100, 6'b000000};
            "s": glyph = {6'b000000, 6'b000000, 6'b011110, 6'b100000, 6'b011100, 6'b000010, 6'b111100, 6'b000000};
            "a": glyph = {6'b000000, 6'b000000, 6'b011100, 6'b000010, 6'b011110, 6'b100010, 6'b011110, 6'b000000};
            "n": glyph = {6'b000000, 6'b000000, 6'b101100, 6'b110010, 6'b100010, 6'b100010, 6'b100010, 6'b000000};
            "y": glyph = {6'b000000, 6'b000000, 6'b100010, 6'b100010, 6'b011110, 6'b000010, 6'b011100, 6'b000000};
            "k": glyph = {6'b100000, 6'b100000, 6'b100100, 6'b101000, 6'b110000, 6'b101000, 6'b100100, 6'b000000};
            "t": glyph = {6'b010000, 6'b010000, 6'b111000, 6'b010000, 6'b010000, 6'b010010, 6'b001100, 6'b000000};
            "o": glyph = {6'b000000, 6'b000000, 6'b011100, 6'b100010, 6'b100010, 6'b100010, 6'b011100, 6'b000000};
            default: glyph = 48'd0;
        endcase
    endfunction

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] char_idx;
    logic [10:0] col_in;
    logic [2:0]  col3;
    logic [2:0]  row3;
    logic [2:0]  row_inv;
    logic [5:0]  shift;
    logic [7:0]  ch;
    logic [47:0] bits;
    logic [5:0]  row_bits;
    logic        in_box;
    logic        hit;

    always_comb begin
        dx       = {1'b0, pixel_x} - {1'b0, x_pos};
        dy       = {1'b0, pixel_y} - {1'b0, y_pos};
        in_box   = (pixel_x >= x_pos) && (pixel_y >= y_pos)
                   && (dx < 11'(SPAN_W)) && (dy < 11'(GLYPH_H));
        char_idx = dx / 11'(CELL_W);
        col_in   = dx - char_idx * 11'(CELL_W);
        col3     = 3'(col_in / 11'(SCALE));
        row3     = 3'(dy / 11'(SCALE));
        ch       = 8'h20;
        for (int i = 0; i < int'(LEN); i++) begin
            if (char_idx == 11'(i)) ch = TEXT[8*(int'(LEN)-1-i) +: 8];
        end
        bits     = glyph(ch);
        row_inv  = 3'd7 - row3;
        shift    = {1'b0, row_inv, 2'b00} + {2'b00, row_inv, 1'b0};
        row_bits = 6'(bits >> shift);
        // Columns past the glyph body fall into the kerning gap.
        hit      = in_box && (col_in < 11'(GLYPH_W)) && (|(row_bits & (6'b100000 >> col3)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pixel_on <= 1'b0;
        else       pixel_on <= hit;
    end
endmodule

module startup_screen_text #(
    parameter int unsigned              KERNING      = 0,
    parameter int unsigned              TITLE_SCALE  = 8,
    parameter int unsigned              PROMPT_SCALE = 3,
    parameter int unsigned              TITLE_LEN    = 4,
    parameter logic [8*TITLE_LEN-1:0]   TITLE_TEXT   = "PONG",
    parameter int unsigned              PROMPT_LEN   = 22,
    parameter logic [8*PROMPT_LEN-1:0]  PROMPT_TEXT  = "Press any key to start",
    parameter int unsigned              TITLE_Y      = 99,
    parameter int unsigned              GAP          = 20,
    parameter int unsigned              SLIDE_STEP   = 4,
    parameter int unsigned              BLINK_FRAMES = 30,
    parameter int unsigned              ANIMATE      = 1
) (
    input  logic                  clk_0,
    input  logic                  rst,
    startup_screen_text_if.slave  bus
);
    localparam int unsigned TITLE_W  = TITLE_LEN * 6 * TITLE_SCALE + (TITLE_LEN - 1) * KERNING;
    localparam int unsigned PROMPT_W = PROMPT_LEN * 6 * PROMPT_SCALE + (PROMPT_LEN - 1) * KERNING;
    localparam int unsigned TITLE_X  = 320 - TITLE_W / 2;
    localparam int unsigned PROMPT_X = 320 - PROMPT_W / 2;
    localparam int unsigned PROMPT_Y = TITLE_Y + 8 * TITLE_SCALE + GAP - 1;
    localparam int unsigned CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {SLIDE, HOLD, DONE} state_t;

    localparam state_t     RST_STATE      = (ANIMATE != 0) ? SLIDE : HOLD;
    localparam logic [9:0] TITLE_REST     = 10'(TITLE_Y);
    localparam logic [9:0] TITLE_Y_RST    = (ANIMATE != 0) ? 10'd0 : TITLE_REST;
    localparam logic       PROMPT_VIS_RST = (ANIMATE == 0);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    state_t           state, state_next;
    logic [9:0]       title_y, title_y_next;
    logic [CNT_W-1:0] blink_cnt, blink_cnt_next;
    logic             prompt_vis, prompt_vis_next;
    logic             pulse_next;
    logic             key_q;
    logic             zero_q;
    logic             zero_now;
    logic             frame_tick;
    logic             key_rise;
    logic             title_on;
    logic             prompt_on;
    logic             title_hit;
    logic             prompt_hit;
    logic             text_hit;
    logic             ready_flag;
    logic             pulse;

    string_display #(
        .LEN(TITLE_LEN), .SCALE(TITLE_SCALE), .KERNING(KERNING), .TEXT(TITLE_TEXT)
    ) u_title (
        .clk(clk_0), .reset(!rst),
        .pixel_x(bus.pixel_x), .pixel_y(bus.pixel_y),
        .x_pos(10'(TITLE_X)), .y_pos(title_y),
        .pixel_on(title_on)
    );

    string_display #(
        .LEN(PROMPT_LEN), .SCALE(PROMPT_SCALE), .KERNING(KERNING), .TEXT(PROMPT_TEXT)
    ) u_prompt (
        .clk(clk_0), .reset(!rst),
        .pixel_x(bus.pixel_x), .pixel_y(bus.pixel_y),
        .x_pos(10'(PROMPT_X)), .y_pos(10'(PROMPT_Y)),
        .pixel_on(prompt_on)
    );

    assign zero_now   = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
    assign frame_tick = zero_now && !zero_q;
    assign key_rise   = bus.key_pressed && !key_q;

    // Next-state logic: restart beats key edges, key edges beat frame ticks.
    always_comb begin
        state_next      = state;
        title_y_next    = title_y;
        blink_cnt_next  = blink_cnt;
        prompt_vis_next = prompt_vis;
        pulse_next      = 1'b0;
        if (bus.restart) begin
            state_next      = RST_STATE;
            title_y_next    = TITLE_Y_RST;
            blink_cnt_next  = '0;
            prompt_vis_next = PROMPT_VIS_RST;
        end else begin
            case (state)
                SLIDE: begin
                    if (key_rise || (frame_tick &&
                        ({1'b0, title_y} + 11'(SLIDE_STEP) >= 11'(TITLE_Y)))) begin
                        state_next      = HOLD;
                        title_y_next    = TITLE_REST;
                        blink_cnt_next  = '0;
                        prompt_vis_next = 1'b1;
                    end else if (frame_tick) begin
                        title_y_next = title_y + 10'(SLIDE_STEP);
                    end
                end
                HOLD: begin
                    if (key_rise) begin
                        state_next = DONE;
                        pulse_next = 1'b1;
                    end else if (frame_tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_next  = '0;
                            prompt_vis_next = !prompt_vis;
                        end else begin
                            blink_cnt_next = blink_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state      <= RST_STATE;
            title_y    <= TITLE_Y_RST;
            blink_cnt  <= '0;
            prompt_vis <= PROMPT_VIS_RST;
            key_q      <= 1'b1;
            zero_q     <= 1'b0;
            ready_flag <= (RST_STATE == HOLD);
            pulse      <= 1'b0;
            title_hit  <= 1'b0;
            prompt_hit <= 1'b0;
            text_hit   <= 1'b0;
        end else begin
            state      <= state_next;
            title_y    <= title_y_next;
            blink_cnt  <= blink_cnt_next;
            prompt_vis <= prompt_vis_next;
            key_q      <= bus.key_pressed;
            zero_q     <= zero_now;
            ready_flag <= (state_next == HOLD);
            pulse      <= pulse_next;
            // Overlay gating uses the state seen in the same cycle as the glyph hit.
            title_hit  <= title_on && (state != DONE);
            prompt_hit <= prompt_on && (state == HOLD) && prompt_vis;
            text_hit   <= (title_on && (state != DONE)) || (prompt_on && (state == HOLD) && prompt_vis);
        end
    end

    assign bus.in_title    = title_hit;
    assign bus.in_prompt   = prompt_hit;
    assign bus.in_text     = text_hit;
    assign bus.ready       = ready_flag;
    assign bus.start_pulse = pulse;
endmodule

// File: tb/tb_startup_screen_text.sv
// Directed bench for the start screen overlay: slide, blink, start, skip,
// restart priority, pixel latency and asynchronous reset.
module tb_startup_screen_text;
    localparam logic [9:0] IDLE_X = 10'd639;
    localparam logic [9:0] IDLE_Y = 10'd479;

    logic clk;
    logic rst;

    startup_screen_text_if ba ();
    startup_screen_text_if bz ();

    startup_screen_text #(.BLINK_FRAMES(2)) dut_a (.clk_0(clk), .rst(rst), .bus(ba));
    startup_screen_text #(.ANIMATE(0))      dut_z (.clk_0(clk), .rst(rst), .bus(bz));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: observed %0h with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
        ba.pixel_x = x;
        ba.pixel_y = y;
        bz.pixel_x = x;
        bz.pixel_y = y;
    endtask

    task automatic tick();
        set_pix(10'd0, 10'd0);
        step();
        set_pix(IDLE_X, IDLE_Y);
        step();
    endtask

    task automatic probe_a(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic et, input logic ep);
        set_pix(x, y);
        sb_push({tag, "_title"}, 32'(et));
        sb_push({tag, "_prompt"}, 32'(ep));
        sb_push({tag, "_text"}, 32'(et | ep));
        step();
        step();
        sb_check(32'(ba.in_title));
        sb_check(32'(ba.in_prompt));
        sb_check(32'(ba.in_text));
        set_pix(IDLE_X, IDLE_Y);
    endtask

    initial begin
        logic        blink_exp [4];
        logic [31:0] pulses;
        blink_exp = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        ba.key_pressed = 1'b1;
        ba.restart     = 1'b0;
        bz.key_pressed = 1'b0;
        bz.restart     = 1'b0;
        set_pix(IDLE_X, IDLE_Y);
        step();
        step();

        // Reset values
        sb_push("rst_text", 0);  sb_check(32'(ba.in_text));
        sb_push("rst_title", 0); sb_check(32'(ba.in_title));
        sb_push("rst_prompt", 0); sb_check(32'(ba.in_prompt));
        sb_push("rst_pulse", 0); sb_check(32'(ba.start_pulse));
        sb_push("rst_ready_anim", 0); sb_check(32'(ba.ready));
        sb_push("rst_ready_static", 1); sb_check(32'(bz.ready));

        // Key held through reset release must not skip the slide
        rst = 1'b1;
        step();
        step();
        sb_push("held_key_no_skip", 0); sb_check(32'(ba.ready));
        ba.key_pressed = 1'b0;
        step();

        // Slide: 25 ticks from row 0 to row 99
        for (int k = 1; k <= 25; k++) begin
            tick();
            sb_push($sformatf("slide_ready_%0d", k), 32'(k == 25));
            sb_check(32'(ba.ready));
            if (k == 1) begin
                probe_a("slide1_top", 10'd224, 10'd4, 1'b1, 1'b0);
                probe_a("slide1_above", 10'd224, 10'd3, 1'b0, 1'b0);
                probe_a("slide1_prompt", 10'd122, 10'd182, 1'b0, 1'b0);
            end
            if (k == 12) begin
                probe_a("slide12_top", 10'd224, 10'd48, 1'b1, 1'b0);
                probe_a("slide12_prompt", 10'd122, 10'd182, 1'b0, 1'b0);
            end
        end
        probe_a("hold_title", 10'd224, 10'd99, 1'b1, 1'b0);
        probe_a("hold_gap", 10'd256, 10'd99, 1'b0, 1'b0);
        probe_a("blink_entry", 10'd122, 10'd182, 1'b0, 1'b1);

        // Blink with two frames per half-period
        for (int j = 0; j < 4; j++) begin
            tick();
            probe_a($sformatf("blink_%0d", j + 1), 10'd122, 10'd182, 1'b0, blink_exp[j]);
        end

        // Start: key held for five cycles gives exactly one pulse
        ba.key_pressed = 1'b1;
        step();
        sb_push("start_pulse_now", 1); sb_check(32'(ba.start_pulse));
        sb_push("start_ready_low", 0); sb_check(32'(ba.ready));
        pulses = 32'(ba.start_pulse);
        for (int c = 0; c < 4; c++) begin
            step();
            pulses = pulses + 32'(ba.start_pulse);
        end
        ba.key_pressed = 1'b0;
        sb_push("start_pulse_count", 1); sb_check(pulses);
        tick();
        probe_a("done_title", 10'd224, 10'd99, 1'b0, 1'b0);
        probe_a("done_prompt", 10'd122, 10'd182, 1'b0, 1'b0);

        // Restart replays the slide from row 0
        ba.restart = 1'b1;
        step();
        ba.restart = 1'b0;
        sb_push("restart_ready", 0); sb_check(32'(ba.ready));
        probe_a("restart_top", 10'd224, 10'd0, 1'b1, 1'b0);

        // Skip on the third tick of the slide
        tick();
        tick();
        set_pix(10'd0, 10'd0);
        ba.key_pressed = 1'b1;
        step();
        sb_push("skip_ready", 1); sb_check(32'(ba.ready));
        sb_push("skip_no_pulse", 0); sb_check(32'(ba.start_pulse));
        ba.key_pressed = 1'b0;
        set_pix(IDLE_X, IDLE_Y);
        step();
        sb_push("skip_no_pulse_late", 0); sb_check(32'(ba.start_pulse));
        probe_a("skip_title", 10'd224, 10'd99, 1'b1, 1'b0);
        probe_a("skip_prompt", 10'd122, 10'd182, 1'b0, 1'b1);
        ba.key_pressed = 1'b1;
        step();
        sb_push("skip_second_pulse", 1); sb_check(32'(ba.start_pulse));
        ba.key_pressed = 1'b0;
        step();
        sb_push("skip_pulse_single", 0); sb_check(32'(ba.start_pulse));

        // Restart beats a simultaneous key edge in HOLD
        ba.restart = 1'b1;
        step();
        ba.restart = 1'b0;
        ba.key_pressed = 1'b1;
        step();
        ba.key_pressed = 1'b0;
        step();
        sb_push("prio_in_hold", 1); sb_check(32'(ba.ready));
        ba.restart = 1'b1;
        ba.key_pressed = 1'b1;
        step();
        ba.restart = 1'b0;
        sb_push("prio_no_pulse", 0); sb_check(32'(ba.start_pulse));
        sb_push("prio_slide", 0); sb_check(32'(ba.ready));
        ba.key_pressed = 1'b0;
        step();
        sb_push("prio_no_pulse_late", 0); sb_check(32'(ba.start_pulse));
        probe_a("prio_top", 10'd224, 10'd0, 1'b1, 1'b0);

        // Two-cycle pixel latency on the static instance
        set_pix(10'd256, 10'd99);
        step();
        step();
        set_pix(10'd224, 10'd99);
        sb_push("lat_early_title", 0);
        sb_push("lat_title", 1);
        sb_push("lat_text", 1);
        step();
        sb_check(32'(bz.in_title));
        step();
        sb_check(32'(bz.in_title));
        sb_check(32'(bz.in_text));
        set_pix(10'd256, 10'd99);
        sb_push("lat_off_title", 0);
        step();
        step();
        sb_check(32'(bz.in_title));

        // Asynchronous reset mid-line clears outputs without a clock edge
        set_pix(10'd224, 10'd99);
        step();
        step();
        sb_push("pre_rst_title", 1); sb_check(32'(bz.in_title));
        #2;
        rst = 1'b0;
        #1;
        sb_push("arst_title", 0);  sb_check(32'(bz.in_title));
        sb_push("arst_text", 0);   sb_check(32'(bz.in_text));
        sb_push("arst_ready_static", 1); sb_check(32'(bz.ready));
        sb_push("arst_ready_anim", 0);   sb_check(32'(ba.ready));
        sb_push("arst_text_anim", 0);    sb_check(32'(ba.in_text));
        #1;
        rst = 1'b1;
        step();
        step();
        sb_push("post_rst_title", 1); sb_check(32'(bz.in_title));

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expectations never compared, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
